mem_arbiter: RTL and testbench

//  Shares the single byte-wide synchronous RAM port between the IF-stage instruction fetch and the MEM-stage load/store unit.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter_byte_seq.sv | 53 +++++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the byte-serial RAM arbiter.
package mem_arbiter_pkg;

  localparam int MEMW_TYPE = 2;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  typedef enum logic [MEMW_TYPE-1:0] {
    NO_MEM_TYPE = 2'd0,
    MEM_B       = 2'd1,
    MEM_H       = 2'd2,
    MEM_W       = 2'd3
  } mem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  function automatic logic [2:0] byte_count(input mem_type_e t);
    case (t)
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/response channels plus the byte-wide RAM port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic              if_clr;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_type;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              mem_busy;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;

  modport slave (
    input  if_req, if_clr, if_addr,
    input  mem_read, mem_write, mem_type, mem_addr, mem_wdata,
    input  ram_din,
    output if_done, if_rdata,
    output mem_done, mem_rdata, mem_busy,
    output ram_dout, ram_addr, ram_wr
  );

  modport master (
    output if_req, if_clr, if_addr,
    output mem_read, mem_write, mem_type, mem_addr, mem_wdata,
    output ram_din,
    input  if_done, if_rdata,
    input  mem_done, mem_rdata, mem_busy,
    input  ram_dout, ram_addr, ram_wr
  );
endinterface

// File: rtl/mem_arbiter_byte_seq.sv
// Byte sequencer: walks the address, selects write bytes and assembles
// read bytes little-endian; read data lags its address by one cycle.
module mem_arbiter_byte_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        n,
  input  logic              dir,
  input  logic [31:0]       wdata,
  input  logic              active,
  input  logic [7:0]        ram_din,
  output logic              last,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        dout,
  output logic [31:0]       word
);
  logic [2:0]  idx;
  logic [2:0]  n_q;
  logic [31:0] wdata_q;
  logic [1:0]  cap_byte;

  // a read needs one extra cycle to catch the final byte
  assign last     = wr ? (idx == n_q - 3'd1) : (idx == n_q);
  assign cap_byte = idx[1:0] - 2'd1;
  assign dout     = wdata_q[{idx[1:0], 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      n_q     <= '0;
      wr      <= 1'b0;
      wdata_q <= '0;
      addr    <= '0;
      word    <= '0;
    end else if (start) begin
      idx     <= '0;
      n_q     <= n;
      wr      <= dir;
      wdata_q <= wdata;
      addr    <= base;
      word    <= '0;
    end else if (active) begin
      idx <= idx + 3'd1;
      if (idx < n_q - 3'd1) addr <= addr + ADDR_W'(1);
      if (!wr && idx != 3'd0) word[{cap_byte, 3'b000} +: 8] <= ram_din;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one byte-wide RAM port
// and serialises each request into byte accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter bit MEM_PRIORITY = 1'b1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | arbitrate and accept one request
  // RD    | issue read addresses, collect bytes one cycle behind
  // WR    | write one byte per cycle
  // DONE  | one-cycle done pulse to the owner
  state_e            state, state_next;
  owner_e            owner;
  logic              mem_valid, if_valid, pick_mem, start, start_wr, abort_if;
  logic [ADDR_W-1:0] start_base;
  logic [2:0]        start_n;
  logic              seq_active, seq_last, seq_wr;
  logic [ADDR_W-1:0] seq_addr;
  logic [7:0]        seq_dout;
  logic [31:0]       seq_word, if_rdata_q, mem_rdata_q;
  logic              if_done, mem_done, ram_wr;

  assign mem_valid  = (bus.mem_read | bus.mem_write) &&
                      (mem_type_e'(bus.mem_type) != NO_MEM_TYPE);
  assign if_valid   = bus.if_req && !bus.if_clr;
  assign pick_mem   = mem_valid && (MEM_PRIORITY || !if_valid);
  assign start      = (state == ST_IDLE) && (mem_valid || if_valid);
  assign start_wr   = pick_mem && bus.mem_write;
  assign start_n    = pick_mem ? byte_count(mem_type_e'(bus.mem_type)) : 3'd4;
  assign start_base = pick_mem ? bus.mem_addr : bus.if_addr;
  assign abort_if   = (owner == OWN_IF) && bus.if_clr;
  assign seq_active = (state == ST_RD) || (state == ST_WR);

  mem_arbiter_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .base   (start_base),
    .n      (start_n),
    .dir    (start_wr),
    .wdata  (bus.mem_wdata),
    .active (seq_active),
    .ram_din(bus.ram_din),
    .last   (seq_last),
    .wr     (seq_wr),
    .addr   (seq_addr),
    .dout   (seq_dout),
    .word   (seq_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_IF;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state <= state_next;
      if (start) owner <= pick_mem ? OWN_MEM : OWN_IF;
      if (if_done) if_rdata_q <= seq_word;
      if (mem_done && !seq_wr) mem_rdata_q <= seq_word;
    end
  end

  always_comb begin
    state_next = state;
    if_done    = 1'b0;
    mem_done   = 1'b0;
    ram_wr     = RAM_READ;
    case (state)
      ST_IDLE: if (start) state_next = start_wr ? ST_WR : ST_RD;
      ST_RD: begin
        if (abort_if)      state_next = ST_IDLE;
        else if (seq_last) state_next = ST_DONE;
      end
      ST_WR: begin
        ram_wr = RAM_WRITE;
        if (seq_last) state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
        // a redirect arriving with the done pulse still kills the fetch
        if_done    = (owner == OWN_IF) && !bus.if_clr;
        mem_done   = (owner == OWN_MEM);
      end
    endcase
  end

  assign bus.ram_wr    = ram_wr;
  assign bus.ram_addr  = seq_addr;
  assign bus.ram_dout  = ram_wr ? seq_dout : 8'h00;
  assign bus.if_done   = if_done;
  assign bus.mem_done  = mem_done;
  assign bus.if_rdata  = if_done ? seq_word : if_rdata_q;
  assign bus.mem_rdata = (mem_done && !seq_wr) ? seq_word : mem_rdata_q;
  assign bus.mem_busy  = mem_valid && !mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-array RAM, reference memory model,
// directed corner cases followed by randomized fetch/load/store traffic.
module tb_mem_arbiter;
  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    bit          chk_lat;
    int          issue;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0, checks = 0, errors = 0;
  int   if_done_cnt = 0, mem_done_cnt = 0, last_if_cyc = 0, last_mem_cyc = 0;
  int   iss, iss2, cnt_before, kind;
  logic [1:0]  t;
  logic [31:0] a, d, fa;
  logic [7:0]  sw_b [4];

  exp_t        if_q[$], mem_q[$];
  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] addr_log [int];
  logic [7:0]  dout_log [int];
  logic        wr_log   [int];
  logic        busy_log [int];

  mem_arbiter_if #(.ADDR_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .MEM_PRIORITY(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (bus.ram_wr) ram[bus.ram_addr] = bus.ram_dout;
    bus.ram_din <= ram.exists(bus.ram_addr) ? ram[bus.ram_addr] : 8'h00;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] addr);
    return ref_mem.exists(addr) ? ref_mem[addr] : 8'h00;
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [7:0] b);
    ram[addr]     = b;
    ref_mem[addr] = b;
  endtask

  // Monitor: logs RAM port activity and scores every done pulse.
  always @(negedge clk) begin
    exp_t e;
    addr_log[cyc] = bus.ram_addr;
    dout_log[cyc] = bus.ram_dout;
    wr_log[cyc]   = bus.ram_wr;
    busy_log[cyc] = bus.mem_busy;
    if (!rst && bus.if_done) begin
      if_done_cnt++;
      last_if_cyc = cyc;
      check("if_expected", if_q.size() != 0, 1'b1);
      if (if_q.size() != 0) begin
        e = if_q.pop_front();
        check("if_rdata", bus.if_rdata, e.data);
        if (e.chk_lat) check("if_latency", cyc - e.issue, e.lat);
      end
    end
    if (!rst && bus.mem_done) begin
      mem_done_cnt++;
      last_mem_cyc = cyc;
      check("mem_expected", mem_q.size() != 0, 1'b1);
      if (mem_q.size() != 0) begin
        e = mem_q.pop_front();
        if (e.chk_data) check("mem_rdata", bus.mem_rdata, e.data);
        if (e.chk_lat) check("mem_latency", cyc - e.issue, e.lat);
      end
    end
  end

  task automatic if_op(input logic [31:0] addr, input bit chk_lat, output int issue);
    exp_t e;
    bit   got;
    e.data     = {ref_rd(addr + 3), ref_rd(addr + 2), ref_rd(addr + 1), ref_rd(addr)};
    e.chk_data = 1'b1;
    e.chk_lat  = chk_lat;
    e.lat      = 6;
    e.issue    = cyc;
    issue      = cyc;
    if_q.push_back(e);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.if_done;
    end
    if (!got) check("if_timeout", got, 1'b1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic mem_op(input bit wr, input bit both, input logic [1:0] ty,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit chk_lat, output int issue);
    exp_t e;
    bit   got;
    int   n;
    n      = (ty == 2'd1) ? 1 : (ty == 2'd2) ? 2 : 4;
    e.data = '0;
    for (int k = 0; k < n; k++) begin
      if (wr) ref_mem[addr + k] = data[8*k +: 8];
      else    e.data[8*k +: 8]  = ref_rd(addr + k);
    end
    e.chk_data = !wr;
    e.chk_lat  = chk_lat;
    e.lat      = wr ? n + 1 : n + 2;
    e.issue    = cyc;
    issue      = cyc;
    mem_q.push_back(e);
    bus.mem_read  = !wr || both;
    bus.mem_write = wr;
    bus.mem_type  = ty;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.mem_done;
    end
    if (!got) check("mem_timeout", got, 1'b1);
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_type  = 2'd0;
    bus.mem_addr  = $urandom();
    bus.mem_wdata = $urandom();
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + $urandom_range(0, 3);
    return 32'h300 + $urandom_range(0, 27);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req = 0; bus.if_clr = 0; bus.if_addr = '0;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_type = 0;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.ram_din = '0;
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    for (int k = 4; k < 16; k++) poke(32'h100 + k, 8'($urandom()));
    for (int k = 0; k < 32; k++) poke(32'h300 + k, 8'($urandom()));
    for (int k = 0; k < 4; k++) begin
      poke(32'hFFFF_FFFC + k, 8'($urandom()));
      poke(k, 8'($urandom()));
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ram_wr", bus.ram_wr, 1'b0);
    check("rst_ram_addr", bus.ram_addr, 32'h0);
    check("rst_ram_dout", bus.ram_dout, 8'h00);
    check("rst_if_done", bus.if_done, 1'b0);
    check("rst_mem_done", bus.mem_done, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    check("rst_mem_busy", bus.mem_busy, 1'b0);

    if_op(32'h100, 1'b1, iss);
    for (int k = 0; k < 4; k++) check("fetch_addr", addr_log[iss + 1 + k], 32'h100 + k);
    check("fetch_rdata_hold", bus.if_rdata, 32'h0000_0513);

    sw_b[0] = 8'hEF; sw_b[1] = 8'hBE; sw_b[2] = 8'hAD; sw_b[3] = 8'hDE;
    mem_op(1'b1, 1'b0, 2'd3, 32'h200, 32'hDEAD_BEEF, 1'b1, iss);
    for (int k = 0; k < 4; k++) begin
      check("sw_ram_wr", wr_log[iss + 1 + k], 1'b1);
      check("sw_ram_addr", addr_log[iss + 1 + k], 32'h200 + k);
      check("sw_ram_dout", dout_log[iss + 1 + k], sw_b[k]);
    end
    check("sw_ram_wr_end", wr_log[iss + 5], 1'b0);
    for (int k = 0; k < 5; k++) check("sw_busy", busy_log[iss + k], 1'b1);
    check("sw_busy_done", busy_log[iss + 5], 1'b0);
    for (int k = 0; k < 4; k++) check("sw_ram_content", ram[32'h200 + k], sw_b[k]);

    poke(32'h203, 8'h80);
    mem_op(1'b0, 1'b0, 2'd1, 32'h203, 32'h0, 1'b1, iss);
    check("lb_rdata_hold", bus.mem_rdata, 32'h0000_0080);

    mem_op(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1, iss);
    check("lh_wrap_addr0", addr_log[iss + 1], 32'hFFFF_FFFF);
    check("lh_wrap_addr1", addr_log[iss + 2], 32'h0000_0000);

    fork
      if_op(32'h100, 1'b0, iss);
      mem_op(1'b0, 1'b0, 2'd3, 32'h200, 32'h0, 1'b1, iss2);
    join
    check("prio_if_after_mem", last_if_cyc, last_mem_cyc + 7);

    // mem_type 0 is ignored entirely
    cnt_before = mem_done_cnt;
    bus.mem_read = 1; bus.mem_write = 1; bus.mem_type = 2'd0; bus.mem_addr = 32'h300;
    iss = cyc;
    #1 check("type0_busy", bus.mem_busy, 1'b0);
    repeat (5) @(posedge clk);
    #1 bus.mem_read = 0; bus.mem_write = 0;
    for (int k = 1; k < 5; k++) check("type0_no_write", wr_log[iss + k], 1'b0);
    check("type0_no_done", mem_done_cnt, cnt_before);

    // redirect during RD
    cnt_before = if_done_cnt;
    bus.if_req = 1; bus.if_addr = 32'h104;
    repeat (2) @(posedge clk);
    #1 bus.if_clr = 1;
    @(posedge clk);
    #1 bus.if_clr = 0; bus.if_req = 0;
    mem_op(1'b0, 1'b0, 2'd3, 32'h300, 32'h0, 1'b1, iss);
    repeat (4) @(posedge clk);
    #1 check("clr_rd_no_done", if_done_cnt, cnt_before);

    // redirect coinciding with the done cycle
    bus.if_req = 1; bus.if_addr = 32'h108;
    repeat (6) @(posedge clk);
    #1 bus.if_clr = 1;
    @(posedge clk);
    #1 bus.if_clr = 0; bus.if_req = 0;
    repeat (3) @(posedge clk);
    #1 check("clr_done_no_done", if_done_cnt, cnt_before);

    // reset in the middle of a store
    cnt_before = mem_done_cnt;
    bus.mem_write = 1; bus.mem_type = 2'd3; bus.mem_addr = 32'h400; bus.mem_wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0; bus.mem_write = 0; bus.mem_type = 2'd0;
    check("rst_mid_sw_ram_wr", bus.ram_wr, 1'b0);
    repeat (8) @(posedge clk);
    #1 check("rst_mid_sw_no_done", mem_done_cnt, cnt_before);
    check("rst_mid_sw_if_rdata", bus.if_rdata, 32'h0);
    check("rst_mid_sw_mem_rdata", bus.mem_rdata, 32'h0);

    for (int r = 0; r < 60; r++) begin
      kind = $urandom_range(0, 3);
      t    = 2'($urandom_range(1, 3));
      a    = rand_addr();
      d    = $urandom();
      fa   = 32'h100 + $urandom_range(0, 8);
      case (kind)
        0: if_op(a, 1'b1, iss);
        1: mem_op(1'b0, 1'b0, t, a, d, 1'b1, iss);
        2: mem_op(1'b1, 1'($urandom_range(0, 1)), t, a, d, 1'b1, iss);
        default: begin
          fork
            if_op(fa, 1'b0, iss);
            mem_op(1'($urandom_range(0, 1)), 1'b0, t, a, d, 1'b1, iss2);
          join
          check("rand_prio_if_after_mem", last_if_cyc, last_mem_cyc + 7);
        end
      endcase
    end

    repeat (10) @(posedge clk);
    #1 check("if_q_drained", if_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
